// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue
// Instruction prefetch buffer feeding the IF/ID latch. It issues one
// word-addressed read at a time over a req/ack handshake and queues up to
// DEPTH {ir, npc} pairs. The queue head is presented to the fetch stage.
// A taken-branch redirect flushes the queue and restarts fetch at the new
// pc. A request that is still outstanding when the redirect arrives is
// completed and its data is dropped.
module fetch_prefetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 10
) (
  input  logic                     clk1,
  input  logic                     rst_n,
  output logic                     mem_req,
  output logic [AW-1:0]            mem_addr,
  input  logic                     mem_ack,
  input  logic [31:0]              mem_rdata,
  output logic                     out_valid,
  output logic [31:0]              out_ir,
  output logic [31:0]              out_npc,
  input  logic                     out_ready,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic                     halt,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // IDLE: no request outstanding.
  // WAIT: a request is outstanding and its data will be kept.
  // DISCARD: a request is outstanding and its data will be dropped.
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;

  logic [1:0]    state_r, state_nxt_s;
  logic [AW-1:0] pc_r, pc_nxt_s;
  logic [AW-1:0] addr_r, addr_nxt_s;
  logic [CW-1:0] count_r, count_nxt_s;
  logic [PW-1:0] rd_ptr_r, wr_ptr_r;
  logic [31:0]   ir_mem_r  [DEPTH];
  logic [AW-1:0] npc_mem_r [DEPTH];

  logic          push_s, pop_s, space_s, has_data_s;
  logic [AW-1:0] addr_inc_s, redirect_addr_s;
  logic          unused_pc_bits_s;

  assign redirect_addr_s  = redirect_pc[AW-1:0];
  assign unused_pc_bits_s = ^redirect_pc[31:AW];
  assign addr_inc_s       = addr_r + AW'(1);

  assign has_data_s = (count_r != {CW{1'b0}});
  assign pop_s      = has_data_s && out_ready && !redirect;
  assign push_s     = (state_r == WAIT) && mem_ack && !redirect;

  // Occupancy after this cycle's push/pop; decides whether a new issue fits.
  always_comb begin
    count_nxt_s = count_r + CW'(push_s) - CW'(pop_s);
    space_s     = (count_nxt_s < DEPTH_C);
  end

  // Fetch FSM next-state, next fetch pc and next request address.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    addr_nxt_s  = addr_r;
    case (state_r)
      IDLE: begin
        if (redirect) begin
          pc_nxt_s = redirect_addr_s;
        end else if (!halt && space_s) begin
          state_nxt_s = WAIT;
          addr_nxt_s  = pc_r;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (!mem_ack) begin
          if (redirect) begin
            state_nxt_s = DISCARD;
            pc_nxt_s    = redirect_addr_s;
          end else begin
            state_nxt_s = WAIT;
          end
        end else if (redirect) begin
          // The returning word belongs to the old path; drop it.
          state_nxt_s = IDLE;
          pc_nxt_s    = redirect_addr_s;
        end else begin
          pc_nxt_s = addr_inc_s;
          if (space_s && !halt) begin
            state_nxt_s = WAIT;
            addr_nxt_s  = addr_inc_s;
          end else begin
            state_nxt_s = IDLE;
          end
        end
      end
      DISCARD: begin
        if (redirect) begin
          pc_nxt_s = redirect_addr_s;
        end else begin
          pc_nxt_s = pc_r;
        end
        if (mem_ack) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DISCARD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM, fetch pc and request address registers.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      pc_r    <= {AW{1'b0}};
      addr_r  <= {AW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      addr_r  <= addr_nxt_s;
    end
  end

  // Queue pointers and entry count; a redirect empties the queue.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      count_r  <= {CW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
    end else if (redirect) begin
      count_r  <= {CW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
    end else begin
      count_r <= count_nxt_s;
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
    end
  end

  // Queue storage: each entry holds the word and its fetch address + 1.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ir_mem_r[i]  <= 32'd0;
        npc_mem_r[i] <= {AW{1'b0}};
      end
    end else if (push_s) begin
      ir_mem_r[wr_ptr_r]  <= mem_rdata;
      npc_mem_r[wr_ptr_r] <= addr_inc_s;
    end
  end

  assign mem_req   = (state_r != IDLE);
  assign mem_addr  = addr_r;
  assign out_valid = has_data_s;
  assign occupancy = count_r;
  assign out_ir    = has_data_s ? ir_mem_r[rd_ptr_r] : 32'd0;
  assign out_npc   = has_data_s ? {{(32-AW){1'b0}}, npc_mem_r[rd_ptr_r]} : 32'd0;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed testbench for fetch_prefetch_queue. The memory model returns
// mem[i] = i + 0x100. The ack is either zero-wait or held off by ack_en.
module tb_fetch_prefetch_queue;

  logic        clk1;
  logic        rst_n;
  logic        mem_req;
  logic [9:0]  mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [31:0] out_ir;
  logic [31:0] out_npc;
  logic        out_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [2:0]  occupancy;
  logic        ack_en;

  int n_cmp;
  int n_err;

  fetch_prefetch_queue #(.DEPTH(4), .AW(10)) dut (
    .clk1        (clk1),
    .rst_n       (rst_n),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .out_valid   (out_valid),
    .out_ir      (out_ir),
    .out_npc     (out_npc),
    .out_ready   (out_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .occupancy   (occupancy)
  );

  assign mem_ack   = mem_req && ack_en;
  assign mem_rdata = {22'd0, mem_addr} + 32'h100;

  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rst_n       = 1'b0;
    out_ready   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    halt        = 1'b1;
    ack_en      = 1'b1;

    // Reset state
    #2;
    check("rst_req",   32'(mem_req),   32'd0);
    check("rst_addr",  32'(mem_addr),  32'd0);
    check("rst_occ",   32'(occupancy), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ir",    out_ir,         32'd0);
    check("rst_npc",   out_npc,        32'd0);
    #10;
    rst_n = 1'b1;
    tick();
    check("halt_noreq", 32'(mem_req), 32'd0);

    // Fill with zero-wait memory and no consumer
    halt = 1'b0;
    tick();
    check("fill_req1",  32'(mem_req),   32'd1);
    check("fill_addr1", 32'(mem_addr),  32'd0);
    check("fill_occ0",  32'(occupancy), 32'd0);
    tick();
    check("fill_occ1",  32'(occupancy), 32'd1);
    check("fill_valid", 32'(out_valid), 32'd1);
    check("fill_ir1",   out_ir,         32'h100);
    check("fill_npc1",  out_npc,        32'd1);
    tick();
    tick();
    tick();
    check("fill_occ4",  32'(occupancy), 32'd4);
    check("fill_noreq", 32'(mem_req),   32'd0);
    tick();
    check("full_noreq", 32'(mem_req),   32'd0);
    check("full_occ",   32'(occupancy), 32'd4);
    check("full_ir",    out_ir,         32'h100);
    check("full_npc",   out_npc,        32'd1);

    // Stream: one pop per clock, npc strictly consecutive
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stream_npc",   out_npc,        32'(i + 2));
      check("stream_ir",    out_ir,         32'(i + 1 + 256));
      check("stream_occ",   32'(occupancy), 32'd3);
      check("stream_valid", 32'(out_valid), 32'd1);
    end

    // Redirect while waiting on a delayed ack
    out_ready   = 1'b0;
    ack_en      = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    check("rdw_occ",   32'(occupancy), 32'd0);
    check("rdw_valid", 32'(out_valid), 32'd0);
    check("rdw_ir",    out_ir,         32'd0);
    check("rdw_req",   32'(mem_req),   32'd1);
    check("rdw_addr",  32'(mem_addr),  32'd13);
    tick();
    check("disc_req",  32'(mem_req),   32'd1);
    check("disc_addr", 32'(mem_addr),  32'd13);
    ack_en = 1'b1;
    tick();
    check("disc_done", 32'(mem_req),   32'd0);
    check("disc_occ",  32'(occupancy), 32'd0);
    tick();
    check("new_req",  32'(mem_req),  32'd1);
    check("new_addr", 32'(mem_addr), 32'h40);
    tick();
    check("new_valid", 32'(out_valid), 32'd1);
    check("new_ir",    out_ir,         32'h140);
    check("new_npc",   out_npc,        32'h41);

    // Redirect coincident with ack and pop, two entries queued
    tick();
    check("r5_occ2",  32'(occupancy), 32'd2);
    check("r5_addr",  32'(mem_addr),  32'h42);
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    out_ready   = 1'b1;
    tick();
    redirect = 1'b0;
    check("r5_occ",   32'(occupancy), 32'd0);
    check("r5_valid", 32'(out_valid), 32'd0);
    check("r5_npc",   out_npc,        32'd0);
    check("r5_req",   32'(mem_req),   32'd0);
    tick();
    check("r5_nreq",  32'(mem_req),  32'd1);
    check("r5_naddr", 32'(mem_addr), 32'h200);
    tick();
    check("r5_ir",   out_ir,         32'h300);
    check("r5_npc2", out_npc,        32'h201);
    check("r5_occ1", 32'(occupancy), 32'd1);

    // Wrap at 1023 and halt after issue
    ack_en      = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h3FF;
    out_ready   = 1'b0;
    tick();
    redirect = 1'b0;
    ack_en   = 1'b1;
    check("w_occ0", 32'(occupancy), 32'd0);
    check("w_disc", 32'(mem_req),   32'd1);
    tick();
    check("w_idle", 32'(mem_req), 32'd0);
    tick();
    check("w_req",  32'(mem_req),  32'd1);
    check("w_addr", 32'(mem_addr), 32'h3FF);
    halt = 1'b1;
    tick();
    check("w_valid", 32'(out_valid), 32'd1);
    check("w_npc",   out_npc,        32'd0);
    check("w_ir",    out_ir,         32'h4FF);
    check("w_hreq",  32'(mem_req),   32'd0);
    tick();
    check("w_hold1", 32'(mem_req), 32'd0);
    tick();
    check("w_hold2", 32'(mem_req), 32'd0);
    halt = 1'b0;
    tick();
    check("w_rreq",  32'(mem_req),   32'd1);
    check("w_raddr", 32'(mem_addr),  32'd0);
    check("w_occ1",  32'(occupancy), 32'd1);

    // Asynchronous reset in the middle of WAIT
    ack_en = 1'b0;
    tick();
    check("mw_req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("ar_req",   32'(mem_req),   32'd0);
    check("ar_addr",  32'(mem_addr),  32'd0);
    check("ar_occ",   32'(occupancy), 32'd0);
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_ir",    out_ir,         32'd0);
    check("ar_npc",   out_npc,        32'd0);
    #10;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
